// File: rtl/sipo_frame_controller.sv
// Receive sequencer for an idle-high serial line. It detects the start bit,
// samples N data bits (LSB first) at mid-bit, and checks the stop bit. Good
// frames are presented on a valid/ready handshake. Sticky flags record
// framing errors and frames dropped because of overrun.
module sipo_frame_controller #(
  parameter int N            = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         serial_in,
  input  logic         data_ready,
  input  logic         clear_err,
  output logic [N-1:0] data_out,
  output logic         data_valid,
  output logic         frame_error,
  output logic         overrun,
  output logic         busy
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(N + 1);

  localparam logic [BW-1:0] HALF_LAST = BW'(H - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] WORD_LAST = CW'(N - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [CW-1:0] bit_q, bit_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [N-1:0]  dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          busy_q;

  // Next-state, bit timing, shifting, handshake and sticky-flag logic
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    valid_d = valid_q && !data_ready;
    ferr_d  = ferr_q && !clear_err;
    ovr_d   = ovr_q && !clear_err;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!serial_in) state_d = START;
      end
      START: begin
        baud_d = baud_q + 1'b1;
        if (baud_q == HALF_LAST) begin
          baud_d = '0;
          if (!serial_in) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        baud_d = baud_q + 1'b1;
        if (baud_q == BIT_LAST) begin
          baud_d         = '0;
          // Shift-then-insert form keeps N == 1 legal (no empty slice)
          shift_d        = shift_q >> 1;
          shift_d[N-1]   = serial_in;
          bit_d          = bit_q + 1'b1;
          if (bit_q == WORD_LAST) state_d = STOP;
        end
      end
      STOP: begin
        baud_d = baud_q + 1'b1;
        if (baud_q == BIT_LAST) begin
          baud_d = '0;
          if (serial_in) begin
            state_d = IDLE;
            if (!valid_q || data_ready) begin
              dout_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        baud_d = '0;
        if (serial_in) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign data_out    = dout_q;
  assign data_valid  = valid_q;
  assign frame_error = ferr_q;
  assign overrun     = ovr_q;
  assign busy        = busy_q;

endmodule

// File: doc/sipo_frame_controller.md
Name: sipo_frame_controller

Overview:
- Receive-side sequencer for the SIPO shift register datapath. Watches an idle-high serial line and detects the start bit.
- Times each bit with an internal bit-period counter and shifts N data bits (LSB first) into its internal shift register.
- Checks the stop bit, then presents the word on a valid/ready handshake to the downstream consumer.
- Flags framing errors and overruns with sticky status bits.

Parameters:
- N, 4, data bits per frame; N >= 1.
- CLKS_PER_BIT, 4, clock cycles per serial bit period; even, >= 2. H = CLKS_PER_BIT/2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- serial_in  input  1  serial line; idle = 1, start bit = 0, then N data bits LSB first, then stop bit = 1.
- data_ready  input  1  consumer accepts data_out when data_valid && data_ready at a rising edge.
- clear_err  input  1  synchronous clear for frame_error and overrun.
- data_out  output  N  last good frame; bit 0 = first data bit received.
- data_valid  output  1  data_out holds an unconsumed frame.
- frame_error  output  1  sticky; a stop bit was sampled as 0.
- overrun  output  1  sticky; a good frame was dropped because data_valid was still 1.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset == 0 at a rising edge):
  - state = IDLE.
  - data_out, data_valid, frame_error, overrun and busy all = 0.
  - Bit-period counter, bit counter and shift register = 0.
  - Reset overrides all other events. A frame in progress is discarded with no flags.
- States: IDLE, START, DATA, STOP, WAIT_IDLE. The bit-period counter (baud_cnt) clears on every state entry.
- IDLE:
  - If serial_in == 0 at an edge (call it e0), go to START.
- START:
  - baud_cnt increments each edge.
  - At the edge where baud_cnt == H-1 (edge e0+H), sample serial_in.
  - Sample 0 -> go to DATA with bit_cnt = 0.
  - Sample 1 -> false start: return to IDLE, set no flags.
- DATA:
  - At the edge where baud_cnt == CLKS_PER_BIT-1, the shift register shifts right and serial_in enters the MSB. Then bit_cnt increments and baud_cnt wraps to 0.
  - Data bit k is sampled at edge e0 + H + (k+1)*CLKS_PER_BIT.
  - After the N-th sample, go to STOP.
- STOP: sample serial_in at the edge where baud_cnt == CLKS_PER_BIT-1 (edge e0 + H + (N+1)*CLKS_PER_BIT).
  - Sample 1 and (data_valid == 0, or data_valid && data_ready at this edge): data_out <= shift register, data_valid <= 1, go to IDLE.
  - Sample 1, data_valid == 1 and data_ready == 0: overrun <= 1, data_out unchanged, new frame dropped, go to IDLE.
  - Sample 0: frame_error <= 1, data_out and data_valid unchanged, go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay until serial_in == 1 at an edge, then go to IDLE.
  - A 0 seen in WAIT_IDLE is never treated as a start bit.
- Handshake:
  - data_valid && data_ready at an edge clears data_valid after that edge, unless a good frame completes on the same edge; then data_valid stays 1 with the new data_out.
  - data_out is stable whenever data_valid == 1 and no new frame is loading.
  - data_ready is ignored while data_valid == 0.
- Sticky flags:
  - clear_err == 1 clears frame_error and overrun at the edge.
  - If a set event occurs on the same edge, set wins.
  - Flags never affect reception.
- busy is registered and is 1 whenever state != IDLE.
- Latency (N=4, CLKS_PER_BIT=4): data_valid rises after edge e0+22, i.e. 22 cycles after start detection.
- Back-to-back frames: a start bit may begin on the first IDLE cycle after STOP.

Test Plan:
- Reset: hold reset = 0 for 2 edges with serial_in toggling -> all outputs 0, busy = 0. Release reset with line idle -> outputs stay 0.
- Good frame: N=4, CLKS_PER_BIT=4; start bit, then data 1,1,0,1 (LSB first), then stop bit 1, each held 4 cycles; data_ready = 1 -> data_out = 4'hB, data_valid high exactly 1 cycle at e0+22, busy high from e0+1 through e0+22.
- Handshake hold: frame 4'h6 with data_ready = 0 -> data_valid stays 1 and data_out = 4'h6 until data_ready is pulsed; data_valid drops the cycle after.
- Overrun: data_ready = 0; send 4'h6, then 4'h9 -> data_out = 4'h6, overrun = 1. Pulse clear_err -> overrun = 0.
- Frame error and glitch:
  - Stop bit driven 0 with data 4'hF -> frame_error = 1, data_valid = 0, controller stays in WAIT_IDLE until the line returns to 1.
  - A separate 1-cycle low glitch in IDLE -> return to IDLE at e0+2 with no flags.
- Reset mid-frame: assert reset during data bit 2 -> next edge all outputs 0. A following full 4'hA frame is received correctly with no error flags.
